// File: rtl/seq_divider4.sv
// seq_divider4: 4-bit restoring sequential divider, one quotient bit per clock.
// Latency: START accepting edge to DONE is 4 edges, or 0 extra edges for a zero divisor.
// Backpressure: none. START is only sampled in IDLE and is ignored while busy or finishing.
//
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   START, A, B       request, 4-bit dividend and 4-bit divisor (captured on the accepting edge)
//   BUSY, DONE        high while calculating, one-cycle pulse when a result is valid
//   Q, R, ZF, DZF     quotient, remainder, quotient-is-zero flag, divide-by-zero flag
// Build option: define DIV_SIGNED_EN for two's-complement operands.
// The divider then works on magnitudes and restores the signs when it writes the result.
module seq_divider4 (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       ZF,
    output logic       DZF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] prem_q, prem_d;     // partial remainder; 5 bits so the shifted value never overflows
    logic [3:0] dvd_q, dvd_d;       // dividend bits shift out of the top while quotient bits shift in at the bottom
    logic [3:0] dvs_q, dvs_d;       // divisor (magnitude)
    logic [1:0] cnt_q, cnt_d;       // remaining steps after the current one
    logic       busy_d, done_d;
    logic [3:0] q_d, r_d;
    logic       zf_d, dzf_d;

    logic [3:0] a_mag, b_mag;
    logic [4:0] shifted, diff;
    logic       ge;
    logic [3:0] q_raw, r_raw, q_fin, r_fin;

`ifdef DIV_SIGNED_EN
    logic neg_q_q, neg_q_d;
    logic neg_r_q, neg_r_d;

    // The magnitude of -8 is 8, which still fits in 4 unsigned bits.
    assign a_mag = A[3] ? (~A + 4'd1) : A;
    assign b_mag = B[3] ? (~B + 4'd1) : B;
    assign q_fin = neg_q_q ? (~q_raw + 4'd1) : q_raw;
    assign r_fin = neg_r_q ? (~r_raw + 4'd1) : r_raw;
`else
    assign a_mag = A;
    assign b_mag = B;
    assign q_fin = q_raw;
    assign r_fin = r_raw;
`endif

    // One restoring step: bring in the next dividend bit, then trial-subtract.
    assign shifted = (prem_q << 1) | {4'b0000, dvd_q[3]};
    assign ge      = (shifted >= {1'b0, dvs_q});
    assign diff    = shifted - {1'b0, dvs_q};
    assign q_raw   = {dvd_q[2:0], ge};
    assign r_raw   = ge ? diff[3:0] : shifted[3:0];

    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        q_d     = Q;
        r_d     = R;
        zf_d    = ZF;
        dzf_d   = DZF;
`ifdef DIV_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    prem_d = 5'd0;
                    dvd_d  = a_mag;
                    dvs_d  = b_mag;
`ifdef DIV_SIGNED_EN
                    neg_q_d = A[3] ^ B[3];
                    neg_r_d = A[3];
`endif
                    if (B == 4'd0) begin
                        // Zero divisor: report immediately and skip the calculation.
                        q_d     = 4'hF;
                        r_d     = A;
                        zf_d    = 1'b0;
                        dzf_d   = 1'b1;
                        done_d  = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = FIN;
                    end else begin
                        cnt_d   = 2'd3;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = ge ? diff : shifted;
                dvd_d  = q_raw;
                if (cnt_q == 2'd0) begin
                    q_d     = q_fin;
                    r_d     = r_fin;
                    zf_d    = (q_fin == 4'd0);
                    dzf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d  = cnt_q - 2'd1;
                    busy_d = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            prem_q  <= 5'd0;
            dvd_q   <= 4'd0;
            dvs_q   <= 4'd0;
            cnt_q   <= 2'd0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            Q       <= 4'd0;
            R       <= 4'd0;
            ZF      <= 1'b1;
            DZF     <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
            Q       <= q_d;
            R       <= r_d;
            ZF      <= zf_d;
            DZF     <= dzf_d;
`ifdef DIV_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider4.sv
// Testbench for seq_divider4: directed literal cases plus randomized stimulus.
// A timeline model of accept/complete edges predicts the outputs every cycle.
// Latency, busy-cycle counts and results are also checked against hand values.
module tb_seq_divider4;

    logic       CLK = 1'b0;
    logic       RST_N, START;
    logic [3:0] A, B;
    logic       BUSY, DONE, ZF, DZF;
    logic [3:0] Q, R;

    int tests = 0;
    int fails = 0;

    seq_divider4 dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .ZF(ZF), .DZF(DZF)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference arithmetic ----------------
    function automatic void ref_div(input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] q, output logic [3:0] r,
                                    output logic zf, output logic dzf);
        int ai, bi, qi, ri;
`ifdef DIV_SIGNED_EN
        ai = $signed(a);
        bi = $signed(b);
`else
        ai = int'(a);
        bi = int'(b);
`endif
        if (bi == 0) begin
            q = 4'hF; r = a; zf = 1'b0; dzf = 1'b1;
        end else begin
            qi = ai / bi;       // truncating division: remainder follows the dividend sign
            ri = ai % bi;
            q = qi[3:0]; r = ri[3:0]; zf = (qi[3:0] == 4'd0); dzf = 1'b0;
        end
    endfunction

    // ---------------- timeline model ----------------
    int         cyc = 0;
    int         acc_k = -100, done_at = -100, free_at = 0;
    logic [3:0] m_q = 4'd0, m_r = 4'd0, p_q, p_r;
    logic       m_zf = 1'b1, m_dzf = 1'b0, p_zf, p_dzf;
    logic       exp_busy = 1'b0, exp_done = 1'b0;

    always @(posedge CLK) begin
        cyc++;
        if (!RST_N) begin
            m_q = 4'd0; m_r = 4'd0; m_zf = 1'b1; m_dzf = 1'b0;
            acc_k = -100; done_at = -100; free_at = cyc + 1;
        end else begin
            if (cyc >= free_at && START) begin
                ref_div(A, B, p_q, p_r, p_zf, p_dzf);
                if (B == 4'd0) begin
                    acc_k = -100; done_at = cyc; free_at = cyc + 2;
                end else begin
                    acc_k = cyc; done_at = cyc + 4; free_at = cyc + 6;
                end
            end
            if (cyc == done_at) begin
                m_q = p_q; m_r = p_r; m_zf = p_zf; m_dzf = p_dzf;
            end
        end
        exp_busy = (cyc >= acc_k) && (cyc <= acc_k + 3);
        exp_done = (cyc == done_at);
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            tests++;
            if (BUSY !== exp_busy || DONE !== exp_done || Q !== m_q || R !== m_r ||
                ZF !== m_zf || DZF !== m_dzf) begin
                fails++;
                $display("FAIL cycle %0d: busy/done/q/r/zf/dzf got %b/%b/%h/%h/%b/%b exp %b/%b/%h/%h/%b/%b",
                         cyc, BUSY, DONE, Q, R, ZF, DZF, exp_busy, exp_done, m_q, m_r, m_zf, m_dzf);
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic ezf, input logic edz, input int elat, input string name);
        int  n, nb;
        bit  seen;
        A = a; B = b; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        n = 0; nb = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK); #1;
            if (DONE) seen = 1;
            else begin
                if (BUSY) nb++;
                @(posedge CLK); #1;
                n++;
            end
        end
        check({name, " latency"}, n, elat);
        check({name, " busy cycles"}, nb, elat);
        check({name, " Q"}, int'(Q), int'(eq));
        check({name, " R"}, int'(R), int'(er));
        check({name, " ZF"}, int'(ZF), int'(ezf));
        check({name, " DZF"}, int'(DZF), int'(edz));
        @(posedge CLK); #1;
    endtask

    initial begin
        int         dcount;
        logic [3:0] dq, dr;
        RST_N = 1'b0; START = 1'b1; A = 4'd5; B = 4'd1;   // START during reset must be ignored
        repeat (2) @(posedge CLK);
        #1 START = 1'b0;
        @(negedge CLK); #1;
        check("reset BUSY", int'(BUSY), 0);
        check("reset DONE", int'(DONE), 0);
        check("reset Q", int'(Q), 0);
        check("reset R", int'(R), 0);
        check("reset ZF", int'(ZF), 1);
        check("reset DZF", int'(DZF), 0);
        @(posedge CLK); #1 RST_N = 1'b1;
        @(posedge CLK); #1;

`ifdef DIV_SIGNED_EN
        run_op(4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 1'b0, 4, "-7/2");
        run_op(4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0, 1'b0, 4, "-8/-1");
        run_op(4'b0110, 4'b1110, 4'b1101, 4'd0,    1'b0, 1'b0, 4, "6/-2");
        run_op(4'b1101, 4'd3,    4'hF,    4'd0,    1'b0, 1'b0, 4, "-3/3");
        run_op(4'd2,    4'd5,    4'd0,    4'd2,    1'b1, 1'b0, 4, "2/5");
`else
        run_op(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 1'b0, 4, "13/3");
        run_op(4'd2,  4'd5, 4'd0,  4'd2, 1'b1, 1'b0, 4, "2/5");
        run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0, 4, "15/1");
`endif
        run_op(4'd9, 4'd0, 4'hF, 4'd9, 1'b0, 1'b1, 0, "9/0");
        run_op(4'd0, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 4, "0/7");

        // Restart attempt during CALC must be ignored.
        A = 4'd12; B = 4'd5; START = 1'b1;
        @(posedge CLK); #1 A = 4'd7; B = 4'd2;
        repeat (3) @(posedge CLK);
        #1 START = 1'b0;
        dcount = 0; dq = 4'd0; dr = 4'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK); #1;
            if (DONE) begin dcount++; dq = Q; dr = R; end
            @(posedge CLK); #1;
        end
        check("restart DONE count", dcount, 1);
`ifdef DIV_SIGNED_EN
        check("restart Q", int'(dq), 0);
        check("restart R", int'(dr), 12);
`else
        check("restart Q", int'(dq), 2);
        check("restart R", int'(dr), 2);
`endif

        // Reset two edges into a 13/3 run aborts it.
        A = 4'd13; B = 4'd3; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        @(posedge CLK); #1 RST_N = 1'b0;
        @(posedge CLK); #1 RST_N = 1'b1;
        @(negedge CLK); #1;
        check("abort BUSY", int'(BUSY), 0);
        check("abort DONE", int'(DONE), 0);
        check("abort Q", int'(Q), 0);
        check("abort R", int'(R), 0);
        check("abort ZF", int'(ZF), 1);
        check("abort DZF", int'(DZF), 0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK); #1;
            if (DONE) dcount++;
        end
        check("abort DONE count", dcount, 0);
        @(posedge CLK); #1;
        run_op(4'd6, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0, 4, "6/2");

        // Randomized traffic, including START during busy and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            START = ($urandom_range(0, 3) == 0);
            A     = 4'($urandom);
            B     = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            RST_N = ($urandom_range(0, 79) != 0);
            @(posedge CLK); #1;
        end
        RST_N = 1'b1; START = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_divider4.md
SEQ_DIVIDER4 -- requirements
Module: seq_divider4

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port START, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port A, input, 4 bits: dividend; captured on the accepting edge.
REQ-005 SHALL have port B, input, 4 bits: divisor; captured on the accepting edge.
REQ-006 SHALL have port BUSY, output reg, 1 bit: high while in CALC.
REQ-007 SHALL have port DONE, output reg, 1 bit: one-cycle pulse when a result is valid.
REQ-008 SHALL have port Q, output reg, 4 bits: quotient.
REQ-009 SHALL have port R, output reg, 4 bits: remainder.
REQ-010 SHALL have port ZF, output reg, 1 bit: zero flag, high when Q==0.
REQ-011 SHALL have port DZF, output reg, 1 bit: divide-by-zero flag.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and FIN.
REQ-013 IDLE with START=1 at edge k SHALL latch A and B, set the iteration counter to 3, and go to CALC; if B==0, SHALL go to FIN instead (see REQ-018).
REQ-014 CALC SHALL perform one restoring-division step per edge, MSB first: shift partial remainder left and bring in the next dividend bit; if partial remainder >= divisor, subtract and set the quotient bit to 1, else set it to 0.
REQ-015 After the 4th step at edge k+4, SHALL write Q, R, ZF and DZF=0, and go to FIN. DONE SHALL be 1 in the cycle after edge k+4; latency START-edge to DONE is 4 edges.
REQ-016 FIN SHALL return to IDLE on the next edge, so DONE is exactly one cycle wide; BUSY SHALL be 0 in FIN.
REQ-017 START SHALL be ignored in CALC and FIN: no restart, and operands are not re-latched.
REQ-018 B==0 at acceptance SHALL set Q=4'hF, R=A, DZF=1, ZF=0, with DONE in the cycle after edge k; CALC is skipped.
REQ-019 Q, R, ZF and DZF SHALL hold their last values until the next completion; input changes after acceptance SHALL have no effect.
REQ-020 Internal partial-remainder width SHALL be 5 bits, so the compare and subtract never overflow.
REQ-021 A==0 SHALL give Q=0, R=0, ZF=1. A<B SHALL give Q=0, R=A, ZF=1.

Reset
REQ-022 RST_N=0 at any edge SHALL force IDLE, BUSY=0, DONE=0, Q=0, R=0, ZF=1, DZF=0, counter=0.
REQ-023 Reset during CALC or FIN SHALL abort the operation with no DONE pulse. A START sampled in the same edge as RST_N=0 SHALL be ignored.

Configuration
REQ-024 Macro DIV_SIGNED_EN defined: A and B SHALL be two's complement. The divider SHALL operate on magnitudes; Q sign = sign(A) XOR sign(B); R takes the sign of A. Negation SHALL be applied in FIN with the same latency. -8/-1 SHALL give Q=4'b1000, R=0. Divide-by-zero behaviour SHALL be as in REQ-018.
REQ-025 Macro DIV_SIGNED_EN undefined: operands and results SHALL be unsigned and no sign logic SHALL be synthesized.

Verification
REQ-026 Unsigned 13/3, START pulsed at edge k -> BUSY high for cycles k+1..k+4; DONE after edge k+4; Q=4, R=1, ZF=0, DZF=0.
REQ-027 2/5 -> Q=0, R=2, ZF=1; 15/1 -> Q=15, R=0.
REQ-028 9/0 -> DONE in the cycle after the accepting edge; Q=4'hF, R=9, DZF=1, BUSY never high.
REQ-029 START re-asserted with new operands 7/2 during CALC of 12/5 -> a single DONE with Q=2, R=2, then IDLE.
REQ-030 RST_N=0 at edge k+2 of a 13/3 run -> no DONE pulse; all outputs at reset values on the next cycle; a fresh 6/2 then gives Q=3, R=0.
REQ-031 With DIV_SIGNED_EN: -7/2 -> Q=4'b1101, R=4'b1111; -8/-1 -> Q=4'b1000, R=0.
